// File: rtl/decode_stage_if.sv
// Bus between fetch/writeback/execute and the decode stage.
// The slave side is decode_stage; the master side is whatever drives it.
interface decode_stage_if #(
  parameter int DW = 16,
  parameter int AW = 4,
  parameter int CW = 16
);
  logic [15:0]   instF;
  logic          validF;
  logic          flushD;
  logic          wbEn;
  logic [AW-1:0] wbAddr;
  logic [DW-1:0] wbData;
  logic          MemToRegE;
  logic [AW-1:0] destAddE;
  logic          stallF;
  logic          flushC;
  logic          RegWriteC;
  logic          MemWriteC;
  logic          MemToRegC;
  logic [1:0]    aluFuncC;
  logic [DW-1:0] srcDataD1;
  logic [DW-1:0] srcDataD2;
  logic [AW-1:0] destAddD;
  logic [CW-1:0] stallCount;

  modport master (
    output instF, validF, flushD, wbEn, wbAddr, wbData, MemToRegE, destAddE,
    input  stallF, flushC, RegWriteC, MemWriteC, MemToRegC, aluFuncC,
           srcDataD1, srcDataD2, destAddD, stallCount
  );

  modport slave (
    input  instF, validF, flushD, wbEn, wbAddr, wbData, MemToRegE, destAddE,
    output stallF, flushC, RegWriteC, MemWriteC, MemToRegC, aluFuncC,
           srcDataD1, srcDataD2, destAddD, stallCount
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction-decode stage: IF/ID register, bypassed register file, control
// decode, load-use hazard detection and a saturating stall counter.
module decode_stage #(
  parameter int DW = 16,
  parameter int AW = 4,
  parameter int CW = 16
) (
  input logic          clk,
  input logic          reset,
  decode_stage_if.slave bus
);
  typedef enum logic [1:0] {
    CLS_ALU   = 2'b00,
    CLS_LOAD  = 2'b01,
    CLS_STORE = 2'b10,
    CLS_NOP   = 2'b11
  } cls_e;

  logic [15:0]   instD_q;
  logic          validD_q;
  logic [DW-1:0] regs_q [2**AW];
  logic [CW-1:0] stallCount_q, stallCount_d;

  cls_e          cls;
  logic [AW-1:0] src1, src2;
  logic          uses_src1, uses_src2;
  logic          wr_ok;
  logic [DW-1:0] rd1, rd2;
  logic          stall;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  assign cls   = cls_e'(instD_q[15:14]);
  assign src1  = instD_q[11:8];
  assign src2  = instD_q[7:4];
  assign wr_ok = bus.wbEn && (bus.wbAddr != '0);

  // Write-through: a same-cycle writeback to the read address wins over the array.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (src1 != '0) rd1 = (wr_ok && bus.wbAddr == src1) ? bus.wbData : regs_q[src1];
    if (src2 != '0) rd2 = (wr_ok && bus.wbAddr == src2) ? bus.wbData : regs_q[src2];
  end

  always_comb begin
    uses_src1 = 1'b0;
    uses_src2 = 1'b0;
    case (cls)
      CLS_ALU:   begin uses_src1 = 1'b1; uses_src2 = 1'b1; end
      CLS_LOAD:  uses_src1 = 1'b1;
      CLS_STORE: begin uses_src1 = 1'b1; uses_src2 = 1'b1; end
      default:   ;
    endcase
  end

  assign stall = validD_q && bus.MemToRegE && (bus.destAddE != '0) &&
                 ((uses_src1 && src1 == bus.destAddE) ||
                  (uses_src2 && src2 == bus.destAddE));

  always_comb begin
    bus.RegWriteC = 1'b0;
    bus.MemWriteC = 1'b0;
    bus.MemToRegC = 1'b0;
    bus.aluFuncC  = 2'b00;
    bus.srcDataD1 = '0;
    bus.srcDataD2 = '0;
    bus.destAddD  = '0;
    if (validD_q) begin
      bus.srcDataD1 = rd1;
      bus.srcDataD2 = rd2;
      bus.destAddD  = instD_q[3:0];
      case (cls)
        CLS_ALU:   begin bus.RegWriteC = 1'b1; bus.aluFuncC = instD_q[13:12]; end
        CLS_LOAD:  begin
          bus.RegWriteC = 1'b1;
          bus.MemToRegC = 1'b1;
          bus.aluFuncC  = instD_q[13:12];
        end
        CLS_STORE: begin bus.MemWriteC = 1'b1; bus.aluFuncC = instD_q[13:12]; end
        default:   ;
      endcase
    end
  end

  assign bus.stallF     = stall;
  assign bus.flushC     = stall;
  assign stallCount_d   = stall ? sat_inc(stallCount_q) : stallCount_q;
  assign bus.stallCount = stallCount_q;

  // IF/ID: flush beats stall so a redirect always kills the held instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instD_q  <= '0;
      validD_q <= 1'b0;
    end else if (bus.flushD) begin
      instD_q  <= '0;
      validD_q <= 1'b0;
    end else if (!stall) begin
      instD_q  <= bus.instF;
      validD_q <= bus.validF;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**AW; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[bus.wbAddr] <= bus.wbData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stallCount_q <= '0;
    else        stallCount_q <= stallCount_d;
  end
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expectations are queued when stimulus is
// driven and compared at the falling edge of the cycle they describe.
module tb_decode_stage;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int CW = 4;

  logic clk;
  logic reset;

  decode_stage_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

  decode_stage #(.DW(DW), .AW(AW), .CW(CW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic          stall;
    logic          rw;
    logic          mw;
    logic          m2r;
    logic [1:0]    alu;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [AW-1:0] dest;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic stall, input logic rw,
                         input logic mw, input logic m2r, input logic [1:0] alu,
                         input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                         input logic [AW-1:0] dest, input logic [CW-1:0] cnt);
    exp_t e;
    e.tag = tag; e.stall = stall; e.rw = rw; e.mw = mw; e.m2r = m2r;
    e.alu = alu; e.d1 = d1; e.d2 = d2; e.dest = dest; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Combinational outputs are settled mid-cycle; compare there.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "/stallF"},     32'(bus.stallF),     32'(e.stall));
      chk({e.tag, "/flushC"},     32'(bus.flushC),     32'(e.stall));
      chk({e.tag, "/RegWriteC"},  32'(bus.RegWriteC),  32'(e.rw));
      chk({e.tag, "/MemWriteC"},  32'(bus.MemWriteC),  32'(e.mw));
      chk({e.tag, "/MemToRegC"},  32'(bus.MemToRegC),  32'(e.m2r));
      chk({e.tag, "/aluFuncC"},   32'(bus.aluFuncC),   32'(e.alu));
      chk({e.tag, "/srcDataD1"},  32'(bus.srcDataD1),  32'(e.d1));
      chk({e.tag, "/srcDataD2"},  32'(bus.srcDataD2),  32'(e.d2));
      chk({e.tag, "/destAddD"},   32'(bus.destAddD),   32'(e.dest));
      chk({e.tag, "/stallCount"}, 32'(bus.stallCount), 32'(e.cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.instF     = 16'h0000;
    bus.validF    = 1'b0;
    bus.flushD    = 1'b0;
    bus.wbEn      = 1'b0;
    bus.wbAddr    = '0;
    bus.wbData    = '0;
    bus.MemToRegE = 1'b0;
    bus.destAddE  = '0;
  endtask

  task automatic fetch(input logic [15:0] inst);
    bus.instF  = inst;
    bus.validF = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    sb_push("reset", 0, 0, 0, 0, 2'd0, 16'h0, 16'h0, 4'd0, 4'd0);
    tick();
    tick();
    reset = 1'b1;

    // Write R3 while ALU 0x0345 enters IF/ID
    bus.wbEn = 1'b1; bus.wbAddr = 4'd3; bus.wbData = 16'h1234;
    fetch(16'h0345);
    tick();
    idle();
    sb_push("alu_r3", 0, 1, 0, 0, 2'd0, 16'h1234, 16'h0000, 4'd5, 4'd0);
    tick();

    // Same-cycle bypass of R7, then a write to R0 that must be dropped
    fetch(16'h0700);
    tick();
    bus.wbEn = 1'b1; bus.wbAddr = 4'd7; bus.wbData = 16'hBEEF;
    fetch(16'h0070);
    sb_push("bypass_r7", 0, 1, 0, 0, 2'd0, 16'hBEEF, 16'h0000, 4'd0, 4'd0);
    tick();
    bus.wbEn = 1'b1; bus.wbAddr = 4'd0; bus.wbData = 16'hFFFF;
    fetch(16'h0000);
    sb_push("r0_bypass", 0, 1, 0, 0, 2'd0, 16'h0000, 16'hBEEF, 4'd0, 4'd0);
    tick();
    idle();
    sb_push("r0_write", 0, 1, 0, 0, 2'd0, 16'h0000, 16'h0000, 4'd0, 4'd0);
    tick();

    // Load-use on ALU src2, single bubble with IF/ID held
    fetch(16'h1425);
    tick();
    idle();
    bus.MemToRegE = 1'b1; bus.destAddE = 4'd2;
    sb_push("lu_alu", 1, 1, 0, 0, 2'd1, 16'h0, 16'h0, 4'd5, 4'd0);
    tick();
    bus.MemToRegE = 1'b0;
    sb_push("lu_alu_held", 0, 1, 0, 0, 2'd1, 16'h0, 16'h0, 4'd5, 4'd1);
    tick();

    // NOP with a matching src2 field never stalls
    fetch(16'hC425);
    tick();
    idle();
    bus.MemToRegE = 1'b1; bus.destAddE = 4'd2;
    sb_push("lu_nop", 0, 0, 0, 0, 2'd0, 16'h0, 16'h0, 4'd5, 4'd1);
    tick();

    // STORE src2 matches the load destination
    idle();
    fetch(16'h8125);
    tick();
    idle();
    bus.MemToRegE = 1'b1; bus.destAddE = 4'd2;
    sb_push("lu_store", 1, 0, 1, 0, 2'd0, 16'h0, 16'h0, 4'd5, 4'd1);
    tick();
    bus.MemToRegE = 1'b0;
    sb_push("lu_store_held", 0, 0, 1, 0, 2'd0, 16'h0, 16'h0, 4'd5, 4'd2);
    fetch(16'h4125);
    tick();
    idle();
    bus.MemToRegE = 1'b1; bus.destAddE = 4'd2;
    sb_push("lu_load_src2", 0, 1, 0, 1, 2'd0, 16'h0, 16'h0, 4'd5, 4'd2);
    tick();

    // Flush during a stall cycle clears IF/ID
    idle();
    fetch(16'h0235);
    tick();
    idle();
    bus.MemToRegE = 1'b1; bus.destAddE = 4'd2; bus.flushD = 1'b1;
    sb_push("flush_stall", 1, 1, 0, 0, 2'd0, 16'h0, 16'h1234, 4'd5, 4'd2);
    tick();
    bus.flushD = 1'b0;
    fetch(16'h0377);
    sb_push("flush_after", 0, 0, 0, 0, 2'd0, 16'h0, 16'h0, 4'd0, 4'd3);
    tick();

    // Asynchronous reset in the middle of a stall
    idle();
    bus.MemToRegE = 1'b1; bus.destAddE = 4'd3;
    sb_push("pre_reset", 1, 1, 0, 0, 2'd0, 16'h1234, 16'hBEEF, 4'd7, 4'd3);
    tick();
    reset = 1'b0;
    sb_push("mid_reset", 0, 0, 0, 0, 2'd0, 16'h0, 16'h0, 4'd0, 4'd0);
    tick();
    reset = 1'b1;
    idle();

    for (int r = 1; r < 16; r++) begin
      logic [15:0] inst;
      inst = {4'h0, 4'(r), 4'(r), 4'h0};
      fetch(inst);
      tick();
      idle();
      sb_push($sformatf("rf_clr_r%0d", r), 0, 1, 0, 0, 2'd0, 16'h0, 16'h0, 4'd0, 4'd0);
    end
    tick();

    // Back-to-back matching loads keep the stall up; counter saturates
    fetch(16'h0235);
    tick();
    idle();
    bus.MemToRegE = 1'b1; bus.destAddE = 4'd2;
    repeat (21) tick();
    sb_push("sat_stall", 1, 1, 0, 0, 2'd0, 16'h0, 16'h0, 4'd5, 4'd15);
    tick();
    bus.MemToRegE = 1'b0;
    sb_push("sat_hold", 0, 1, 0, 0, 2'd0, 16'h0, 16'h0, 4'd5, 4'd15);
    tick();
    tick();

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage of the 16-bit pipelined CPU. Sits between fetch and the ID/EX pipeline register, and drives that register's C/D-suffixed inputs plus its flushC.
- Contains the IF/ID pipeline register, a 16x16 register file with write-back port and write-through bypass, control decode, load-use hazard detection and a stall counter.

Parameters:
- DW, 16, data/register width
- AW, 4, register address width (2^AW registers)
- CW, 16, stall counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- instF  in  16  fetched instruction
- validF  in  1  instF valid this cycle
- flushD  in  1  kill instruction in IF/ID (branch/redirect)
- wbEn  in  1  register-file write enable from WB
- wbAddr  in  AW  write-back register address
- wbData  in  DW  write-back data
- MemToRegE  in  1  ID/EX holds a load
- destAddE  in  AW  ID/EX destination register
- stallF  out  1  hold PC/fetch this cycle
- flushC  out  1  insert bubble into ID/EX
- RegWriteC  out  1  decoded register write
- MemWriteC  out  1  decoded memory write
- MemToRegC  out  1  decoded load
- aluFuncC  out  2  ALU function
- srcDataD1  out  DW  source operand 1
- srcDataD2  out  DW  source operand 2 / store data
- destAddD  out  AW  destination register
- stallCount  out  CW  saturating count of hazard stall cycles

Behaviour:
- Instruction format: [15:14] class, [13:12] aluFunc, [11:8] src1, [7:4] src2, [3:0] dest.
- Class decode:
  - 00 ALU: RegWrite=1, uses src1 and src2.
  - 01 LOAD: RegWrite=1, MemToReg=1, uses src1.
  - 10 STORE: MemWrite=1, uses src1 and src2.
  - 11 NOP: all controls 0.
- IF/ID register (instD, validD), updated on posedge clk, priority order:
  1. reset low: validD=0, instD=0.
  2. flushD=1: validD=0, instD=0. Applies even while stalling.
  3. stall=1: hold both.
  4. otherwise: instD<=instF, validD<=validF.
- Decode outputs are combinational from instD/validD and the register file.
  - validD=0: RegWriteC, MemWriteC, MemToRegC=0; aluFuncC, destAddD=0; srcData=0.
  - destAddD = instD[3:0] when valid.
- Register file:
  - 16 entries, all cleared to 0 on reset.
  - Written at posedge clk when wbEn=1 and wbAddr!=0.
  - R0 reads 0 always; writes to R0 are ignored.
- Read bypass: if wbEn=1, wbAddr!=0 and wbAddr equals the read address, srcData takes wbData in the same cycle (write-through).
- Hazard detection (combinational): stall = validD & MemToRegE & (destAddE!=0) & ((src1==destAddE) | (used src2==destAddE)).
  - src2 counts only for ALU and STORE classes.
  - NOP never stalls.
- On stall:
  - stallF=1 and flushC=1 in the same cycle.
  - Decoded controls still present, but ID/EX discards them via flushC.
  - Exactly one bubble per load-use hazard: the next cycle the load has left EX, so the stall clears unless the new EX instruction is another matching load.
- flushD and stall in the same cycle: the flush wins on IF/ID; stallF and flushC still follow the combinational stall equation for that cycle.
- stallCount: +1 per clock with stall=1; saturates at 2^CW-1; reset to 0.
- Reset values: all outputs 0. The register file and IF/ID clear immediately on reset assertion (asynchronous), and outputs show the bubble values.
- Reset mid-stall: stall drops immediately because validD=0.

Test Plan:
- Reset, then write R3=0x1234 via wbEn; next cycle decode ALU inst 0x0345 (src1=R3, src2=R4, dest=R5) -> srcDataD1=0x1234, srcDataD2=0, RegWriteC=1, aluFuncC=00, destAddD=5.
- Same-cycle bypass: wbEn=1, wbAddr=7, wbData=0xBEEF while instD reads src1=R7 -> srcDataD1=0xBEEF in that cycle. Write to R0 with 0xFFFF -> R0 still reads 0.
- Load-use: MemToRegE=1, destAddE=2, instD ALU with src2=R2 -> stallF=1, flushC=1 for exactly one cycle, instD held, stallCount=1. Identical case with a NOP instD -> no stall.
- STORE with src2 match to the load destination stalls; LOAD whose only src2 field matches does not stall.
- flushD asserted during a stall cycle -> next cycle validD=0, all control outputs 0, stall deasserted.
- Assert reset mid-operation after registers are written -> all outputs 0 immediately; after release every register reads 0 and stallCount=0. Force 2^CW+5 stall cycles (CW=4 build) -> stallCount holds 15.
